// File: rtl/adder_sum_accumulator.sv
// Sums NUM_SAMPLES accepted sums into one batch total with a sticky overflow flag.
// Result is visible the cycle after the final accept; input stalls (in_ready=0) while the result waits.
module adder_sum_accumulator #(
   parameter int IN_W        = 9,
   parameter int ACC_W       = 16,
   parameter int NUM_SAMPLES = 4,
   parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_data,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);

   generate
      if (ACC_W < IN_W) begin : g_bad_acc_w
         $error("adder_sum_accumulator: ACC_W must be >= IN_W");
      end
      if (NUM_SAMPLES < 1) begin : g_bad_num_samples
         $error("adder_sum_accumulator: NUM_SAMPLES must be >= 1");
      end
   endgenerate

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf_acc;
   logic             r_out_valid;
   logic [ACC_W-1:0] r_out_sum;
   logic             r_out_ovf;

   logic             w_in_ready;
   logic             w_accept;
   logic             w_last;
   logic [ACC_W:0]   w_sum;

   // Top bit of w_sum is the carry-out of the ACC_W-bit addition.
   assign w_sum    = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, in_data};
   assign w_last   = (r_cnt == CNT_W'(NUM_SAMPLES - 1));
   assign w_accept = in_valid && w_in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         ACCUM: begin
            w_in_ready = 1'b1;
            if (in_valid && w_last) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               w_state_nxt = ACCUM;
            end
         end
         default: w_state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_ovf_acc   <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
         r_out_ovf   <= 1'b0;
      end else if (w_accept) begin
         if (w_last) begin
            r_out_sum   <= w_sum[ACC_W-1:0];
            r_out_ovf   <= r_ovf_acc | w_sum[ACC_W];
            r_out_valid <= 1'b1;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
         end else begin
            r_acc       <= w_sum[ACC_W-1:0];
            r_ovf_acc   <= r_ovf_acc | w_sum[ACC_W];
            r_cnt       <= r_cnt + CNT_W'(1);
         end
      end else if (r_state == HOLD && out_ready) begin
         // out_sum/out_ovf deliberately keep their values after the handshake.
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;
   assign out_ovf   = r_out_ovf;

endmodule

// File: doc/adder_sum_accumulator.md
Name: adder_sum_accumulator

Overview:
- Downstream stage of the 8-bit registered adder.
- Consumes the adder's 9-bit registered sum, one sample per accepted handshake.
- Accumulates NUM_SAMPLES consecutive sums into a wider total with a sticky per-batch overflow flag.
- Presents the batch total on a valid/ready output port, holding it stable until the sink accepts it.

Parameters:
- IN_W, 9: input sample width. Matches the adder output width.
- ACC_W, 16: accumulator and output width. Must be >= IN_W. Elaboration error otherwise.
- NUM_SAMPLES, 4: samples per batch. Must be >= 1. Elaboration error otherwise.
- CNT_W, $clog2(NUM_SAMPLES+1): sample counter width. Derived; do not override.

Ports:
- clk, input, 1: clock. All state updates on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: in_data holds a valid sum. Driven by the adder's input strobe delayed one cycle, aligned to its registered out.
- in_data, input, IN_W: sum sample from the adder.
- in_ready, output, 1: block can accept a sample this cycle.
- out_valid, output, 1: out_sum and out_ovf hold a completed batch.
- out_ready, input, 1: sink accepts the batch this cycle.
- out_sum, output, ACC_W: batch total, modulo 2^ACC_W.
- out_ovf, output, 1: batch total exceeded 2^ACC_W-1.

Behaviour:
- Reset, asynchronous, on rst=1: state=ACCUM, acc=0, cnt=0, ovf_acc=0, out_valid=0, out_sum=0, out_ovf=0. in_ready=1 once state=ACCUM.
- Reset mid-batch or mid-hold discards the partial batch or the pending output. No output is produced for it.
- in_ready is combinational: 1 iff state==ACCUM. It does not depend on in_valid.
- Sample accept: in_valid && in_ready at a rising edge.
- ACCUM state, on accept when cnt < NUM_SAMPLES-1:
  - acc <= acc + zero-extended in_data, with the ACC_W-bit result kept.
  - ovf_acc <= ovf_acc | carry-out of that addition.
  - cnt <= cnt+1.
- ACCUM state, on accept when cnt == NUM_SAMPLES-1 (final sample):
  - out_sum <= acc + in_data, truncated to ACC_W.
  - out_ovf <= ovf_acc | carry.
  - out_valid <= 1.
  - acc, cnt and ovf_acc cleared.
  - state <= HOLD.
- ACCUM state, no accept: all state holds, including idle gaps of any length between samples.
- HOLD state:
  - in_ready=0. in_valid is ignored; upstream must hold its sample or drop it by system contract.
  - out_sum, out_ovf and out_valid stay stable while out_ready=0.
- HOLD state, on out_valid && out_ready: out_valid <= 0 and state <= ACCUM. in_ready returns to 1 the following cycle, so there is one bubble cycle per batch.
- Latency: out_valid rises on the clock edge that accepts the final sample. It is visible in the cycle after that accept.
- Throughput: at most NUM_SAMPLES samples per NUM_SAMPLES+1 cycles, assuming out_ready is tied high.
- NUM_SAMPLES=1: every accepted sample becomes a batch. out_sum = in_data, out_ovf = 0, and the block alternates ACCUM/HOLD.
- Overflow is sticky within a batch only. A new batch starts with the flag cleared.
- out_sum and out_ovf keep their last values after out_valid drops, until the next batch completes. Consumers must qualify them with out_valid.
- No X propagation: in_data is sampled only on an accept.

Test Plan:
1. Reset check: assert rst asynchronously between clock edges -> outputs clear immediately: out_valid=0, out_sum=0, out_ovf=0. After release, in_ready=1.
2. Basic batch (defaults, out_ready=1): in_data 10, 20, 30, 40 on consecutive cycles -> one cycle later out_valid=1, out_sum=100, out_ovf=0. in_ready=0 for exactly one cycle.
3. Backpressure: complete a batch of 5, 5, 5, 5 with out_ready=0 for 6 cycles and in_valid held 1 with in_data=7 -> out_sum stays 20 throughout and no sample is accepted. Raise out_ready -> out_valid drops and in_ready=1 next cycle. The first accepted sample is 7.
4. Overflow (ACC_W=10): 510, 510, 510, 510 -> out_sum=1016 (2040 mod 1024), out_ovf=1. Next batch 1, 1, 1, 1 -> out_sum=4, out_ovf=0.
5. Reset mid-batch: accept 100 and 200, then pulse rst -> state cleared. Next 4 samples of 3 -> out_sum=12, not 312.
6. Gapped input: 1, 2, 3, 4 with 0–3 idle in_valid=0 cycles between samples -> out_sum=10. out_valid rises exactly one cycle after the 4th accept.
